// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe
// Four-stage pipelined IEEE-754 style adder/subtractor with flush-to-zero for
// subnormals and round-to-nearest-even.  The whole pipeline moves forward as one
// unit whenever the output register is empty or being consumed.
//
// Ports:
//   clock      - rising-edge clock
//   resetn     - asynchronous active-low reset, discards everything in flight
//   in_valid   - operand pair present on dataa/datab/add_sub
//   in_ready   - pipeline accepts a pair this cycle
//   add_sub    - 1: dataa+datab, 0: dataa-datab
//   dataa      - first operand  (sign|exponent|fraction)
//   datab      - second operand (sign|exponent|fraction)
//   result     - packed sum/difference
//   flags      - {invalid, overflow, underflow}
//   out_valid  - result/flags valid
//   out_ready  - consumer accepts the result
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 add_sub,
  input  logic [EXP_W+MAN_W:0] dataa,
  input  logic [EXP_W+MAN_W:0] datab,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]           flags,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W   = 1 + EXP_W + MAN_W;
  // Working significand: hidden bit, fraction, guard, round, sticky
  localparam int N   = MAN_W + 4;
  // Exponent with headroom for carries and a sign for underflow
  localparam int EW  = EXP_W + 2;
  localparam int SW  = $clog2(MAN_W + 4);
  localparam int LZW = $clog2(MAN_W + 5);
  localparam logic [EXP_W-1:0]    SHIFT_SAT = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]        QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------- stage 1
  logic             a_sign, b_sign, eff_sub, a_larger;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MAN_W:0]   a_man, b_man;
  logic [W-2:0]     a_mag, b_mag;
  logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic             spec_hit;
  logic [W-1:0]     spec_res;
  logic [2:0]       spec_flags;

  // Classify both operands, decide special results and order by magnitude.
  // Subnormals are treated as signed zeros from here on.
  always_comb begin
    a_sign = dataa[W-1];
    b_sign = datab[W-1] ^ ~add_sub;
    a_exp  = dataa[MAN_W +: EXP_W];
    b_exp  = datab[MAN_W +: EXP_W];
    a_frac = dataa[MAN_W-1:0];
    b_frac = datab[MAN_W-1:0];
    a_nan  = (&a_exp) && (|a_frac);
    b_nan  = (&b_exp) && (|b_frac);
    a_snan = a_nan && !a_frac[MAN_W-1];
    b_snan = b_nan && !b_frac[MAN_W-1];
    a_inf  = (&a_exp) && !(|a_frac);
    b_inf  = (&b_exp) && !(|b_frac);
    a_mag  = (a_exp == '0) ? '0 : dataa[W-2:0];
    b_mag  = (b_exp == '0) ? '0 : datab[W-2:0];
    a_man  = (a_exp == '0) ? '0 : {1'b1, a_frac};
    b_man  = (b_exp == '0) ? '0 : {1'b1, b_frac};
    eff_sub  = a_sign ^ b_sign;
    a_larger = a_mag >= b_mag;

    spec_hit   = 1'b0;
    spec_res   = '0;
    spec_flags = 3'b000;
    if (a_nan || b_nan) begin
      spec_hit   = 1'b1;
      spec_res   = QNAN;
      spec_flags = {a_snan || b_snan, 2'b00};
    end else if (a_inf && b_inf && eff_sub) begin
      spec_hit   = 1'b1;
      spec_res   = QNAN;
      spec_flags = 3'b100;
    end else if (a_inf) begin
      spec_hit = 1'b1;
      spec_res = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_hit = 1'b1;
      spec_res = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid, s1_special, s1_sign, s1_sub;
  logic [W-1:0]     s1_spec_res;
  logic [2:0]       s1_spec_flags;
  logic [EXP_W-1:0] s1_exp_l, s1_exp_diff;
  logic [MAN_W:0]   s1_man_l, s1_man_s;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid      <= 1'b0;
      s1_special    <= 1'b0;
      s1_sign       <= 1'b0;
      s1_sub        <= 1'b0;
      s1_spec_res   <= '0;
      s1_spec_flags <= '0;
      s1_exp_l      <= '0;
      s1_exp_diff   <= '0;
      s1_man_l      <= '0;
      s1_man_s      <= '0;
    end else if (advance) begin
      s1_valid      <= in_valid;
      s1_special    <= spec_hit;
      s1_sub        <= eff_sub;
      s1_spec_res   <= spec_res;
      s1_spec_flags <= spec_flags;
      if (a_larger) begin
        s1_sign     <= a_sign;
        s1_exp_l    <= a_exp;
        s1_exp_diff <= a_exp - b_exp;
        s1_man_l    <= a_man;
        s1_man_s    <= b_man;
      end else begin
        s1_sign     <= b_sign;
        s1_exp_l    <= b_exp;
        s1_exp_diff <= b_exp - a_exp;
        s1_man_l    <= b_man;
        s1_man_s    <= a_man;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [SW-1:0] align_sh;
  logic [N-2:0]  align_ext, align_mask, align_shifted;
  logic          align_sticky;

  // Shift the smaller significand right; the shift saturates so that a far
  // smaller operand collapses entirely into the sticky bit.
  always_comb begin
    align_sh      = (s1_exp_diff > SHIFT_SAT) ? SW'(MAN_W + 3) : s1_exp_diff[SW-1:0];
    align_ext     = {s1_man_s, 2'b00};
    align_shifted = align_ext >> align_sh;
    align_mask    = ~({(N-1){1'b1}} << align_sh);
    align_sticky  = |(align_ext & align_mask);
  end

  logic             s2_valid, s2_special, s2_sign, s2_sub;
  logic [W-1:0]     s2_spec_res;
  logic [2:0]       s2_spec_flags;
  logic [EXP_W-1:0] s2_exp_l;
  logic [N-1:0]     s2_man_l, s2_man_s;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_valid      <= 1'b0;
      s2_special    <= 1'b0;
      s2_sign       <= 1'b0;
      s2_sub        <= 1'b0;
      s2_spec_res   <= '0;
      s2_spec_flags <= '0;
      s2_exp_l      <= '0;
      s2_man_l      <= '0;
      s2_man_s      <= '0;
    end else if (advance) begin
      s2_valid      <= s1_valid;
      s2_special    <= s1_special;
      s2_sign       <= s1_sign;
      s2_sub        <= s1_sub;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
      s2_exp_l      <= s1_exp_l;
      s2_man_l      <= {s1_man_l, 3'b000};
      s2_man_s      <= {align_shifted, align_sticky};
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [N:0]             add_sum;
  logic [LZW-1:0]         add_lz;
  logic                   add_found;
  logic [N-1:0]           add_norm;
  logic signed [EW-1:0]   add_exp;
  logic                   add_zero;

  // Operands are ordered, so subtraction never goes negative.  A carry-out
  // shifts right by one (folding into sticky); otherwise normalise left by
  // the leading-zero count.
  always_comb begin
    add_sum   = s2_sub ? ({1'b0, s2_man_l} - {1'b0, s2_man_s})
                       : ({1'b0, s2_man_l} + {1'b0, s2_man_s});
    add_zero  = (add_sum == '0);
    add_lz    = '0;
    add_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!add_found) begin
        if (add_sum[i]) add_found = 1'b1;
        else            add_lz    = add_lz + LZW'(1);
      end
    end
    if (add_sum[N]) begin
      add_norm = {add_sum[N:2], add_sum[1] | add_sum[0]};
      add_exp  = $signed({2'b00, s2_exp_l}) + $signed(EW'(1));
    end else begin
      add_norm = add_sum[N-1:0] << add_lz;
      add_exp  = $signed({2'b00, s2_exp_l}) - $signed({{(EW-LZW){1'b0}}, add_lz});
    end
  end

  logic                 s3_valid, s3_special, s3_sign, s3_zero;
  logic [W-1:0]         s3_spec_res;
  logic [2:0]           s3_spec_flags;
  logic signed [EW-1:0] s3_exp;
  logic [N-1:0]         s3_norm;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s3_valid      <= 1'b0;
      s3_special    <= 1'b0;
      s3_sign       <= 1'b0;
      s3_zero       <= 1'b0;
      s3_spec_res   <= '0;
      s3_spec_flags <= '0;
      s3_exp        <= '0;
      s3_norm       <= '0;
    end else if (advance) begin
      s3_valid      <= s2_valid;
      s3_special    <= s2_special;
      // An exact cancellation is +0; same-sign zeros keep their sign
      s3_sign       <= (add_zero && s2_sub) ? 1'b0 : s2_sign;
      s3_zero       <= add_zero;
      s3_spec_res   <= s2_spec_res;
      s3_spec_flags <= s2_spec_flags;
      s3_exp        <= add_exp;
      s3_norm       <= add_norm;
    end
  end

  // ---------------------------------------------------------------- stage 4
  logic                 rnd_up;
  logic [MAN_W+1:0]     rnd_sum;
  logic [MAN_W-1:0]     rnd_frac;
  logic signed [EW-1:0] rnd_exp;
  logic [W-1:0]         rnd_res;
  logic [2:0]           rnd_flags;

  // Round to nearest even; a carry out of the significand bumps the exponent
  // and leaves an all-zero fraction.  Range checks use the rounded exponent.
  always_comb begin
    rnd_up   = s3_norm[2] && (s3_norm[1] || s3_norm[0] || s3_norm[3]);
    rnd_sum  = {1'b0, s3_norm[N-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    rnd_exp  = s3_exp + $signed({{(EW-1){1'b0}}, rnd_sum[MAN_W+1]});
    rnd_frac = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
    rnd_res   = {s3_sign, rnd_exp[EXP_W-1:0], rnd_frac};
    rnd_flags = 3'b000;
    if (s3_special) begin
      rnd_res   = s3_spec_res;
      rnd_flags = s3_spec_flags;
    end else if (s3_zero) begin
      rnd_res = {s3_sign, {(W-1){1'b0}}};
    end else if (rnd_exp >= EXP_TOP) begin
      rnd_res   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 3'b010;
    end else if (rnd_exp < 1) begin
      rnd_res   = {s3_sign, {(W-1){1'b0}}};
      rnd_flags = 3'b001;
    end
  end

  // Output register: bubbles move through without raising out_valid
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        result <= rnd_res;
        flags  <= rnd_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe
// Self-checking bench for fp_addsub_pipe: directed corner cases, a stalled
// stream, reset with work in flight, randomized traffic against an exact
// integer reference model, and a double-width instance.
module tb_fp_addsub_pipe;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, add_sub, out_valid, out_ready;
  logic [31:0] dataa, datab, result;
  logic [2:0]  flags;

  logic        in_valid64, in_ready64, add_sub64, out_valid64, out_ready64;
  logic [63:0] dataa64, datab64, result64;
  logic [2:0]  flags64;

  int          num_checks = 0;
  int          num_fails  = 0;
  int          popped     = 0;
  logic [34:0] exp_q[$];

  always #5 clock = ~clock;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .add_sub(add_sub), .dataa(dataa), .datab(datab), .result(result),
    .flags(flags), .out_valid(out_valid), .out_ready(out_ready)
  );

  fp_addsub_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid64), .in_ready(in_ready64),
    .add_sub(add_sub64), .dataa(dataa64), .datab(datab64), .result(result64),
    .flags(flags64), .out_valid(out_valid64), .out_ready(out_ready64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Exact reference: both finite operands become integers on a common scale
  // (larger significand shifted up 64 places), are summed exactly, and the
  // sum is rounded to 24 bits by remainder comparison.  A operand more than
  // 64 places down is replaced by a unit epsilon, which rounds identically.
  // Returns {flags, result}.
  function automatic logic [34:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                         input logic op);
    logic sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, rs;
    int ea, eb, el, p, sh, e;
    logic [23:0] ma, mb;
    logic signed [127:0] va, vb, sum;
    logic [127:0] mag, q, rem, half;
    sa = a[31];
    sb = b[31] ^ !op;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan) return {a_snan || b_snan, 2'b00, 32'h7FC00000};
    if (a_inf && b_inf && (sa != sb)) return {3'b100, 32'h7FC00000};
    if (a_inf) return {3'b000, sa, 8'hFF, 23'h0};
    if (b_inf) return {3'b000, sb, 8'hFF, 23'h0};
    ma = (ea == 0) ? 24'h0 : {1'b1, a[22:0]};
    mb = (eb == 0) ? 24'h0 : {1'b1, b[22:0]};
    if (ma == 0 && mb == 0) return {3'b000, sa && sb, 31'h0};
    if (ma == 0) return {3'b000, sb, b[30:0]};
    if (mb == 0) return {3'b000, sa, a[30:0]};
    el = (ea > eb) ? ea : eb;
    va = (el - ea <= 64) ? 128'(ma) << (64 - (el - ea)) : 128'd1;
    vb = (el - eb <= 64) ? 128'(mb) << (64 - (el - eb)) : 128'd1;
    if (sa) va = -va;
    if (sb) vb = -vb;
    sum = va + vb;
    if (sum == 0) return 35'h0;
    rs  = sum < 0;
    mag = rs ? 128'(-sum) : 128'(sum);
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag & ((128'd1 << sh) - 128'd1);
    half = 128'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 128'd1;
    e = el + p - 87;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b010, rs, 8'hFF, 23'h0};
    if (e < 1)    return {3'b001, rs, 31'h0};
    return {3'b000, rs, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] genOperand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0: v[30:0]  = 31'h0;
      1: v[30:0]  = {8'hFF, 23'h0};
      2: v[30:22] = 9'h1FF;
      3: begin v[30:23] = 8'hFF; v[22] = 1'b0; v[0] = 1'b1; end
      4: v[30:23] = 8'h00;
      5: v[30:23] = 8'($urandom_range(250, 254));
      6: v[30:23] = 8'($urandom_range(1, 4));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Second operand is often near the first so cancellation and rounding
  // carries are exercised.
  function automatic logic [31:0] genPartner(input logic [31:0] a);
    logic [31:0] v;
    int e;
    case ($urandom_range(0, 7))
      0: v = a;
      1, 2, 3: begin
        v = $urandom;
        e = int'(a[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
      end
      default: v = genOperand();
    endcase
    return v;
  endfunction

  // Scoreboard push on every accepted pair
  always @(posedge clock) begin
    if (resetn && in_valid && in_ready) exp_q.push_back(ref32(dataa, datab, add_sub));
  end

  // Every valid output (stalled or not) is compared against the oldest
  // outstanding expectation; it is retired only when consumed.
  always @(negedge clock) begin
    if (resetn && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 64'(out_valid), 64'(0));
      end else begin
        checkOutput("sb_result", 64'(result), 64'(exp_q[0][31:0]));
        checkOutput("sb_flags", 64'(flags), 64'(exp_q[0][34:32]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  // Single pair into an idle pipeline; checks latency and the given answer
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic op, input logic [31:0] want_res,
                               input logic [2:0] want_flags);
    int lat;
    dataa    = a;
    datab    = b;
    add_sub  = op;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(4));
    checkOutput({tag, "_result"}, 64'(result), 64'(want_res));
    checkOutput({tag, "_flags"}, 64'(flags), 64'(want_flags));
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, sent, stale, n, lat, p0;
    logic acc;
    resetn      = 1'b0;
    in_valid    = 1'b0;
    add_sub     = 1'b1;
    dataa       = '0;
    datab       = '0;
    out_ready   = 1'b1;
    in_valid64  = 1'b0;
    add_sub64   = 1'b1;
    dataa64     = '0;
    datab64     = '0;
    out_ready64 = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_result", 64'(result), 64'(0));
    checkOutput("rst_flags", 64'(flags), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    resetn = 1'b1;

    applyStimulus("add_1_2",   32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 3'b000);
    applyStimulus("sub_equal", 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000);
    applyStimulus("neg_zeros", 32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 3'b000);
    applyStimulus("tie_even",  32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 3'b000);
    applyStimulus("tie_up",    32'h3F800001, 32'h33800000, 1'b1, 32'h3F800002, 3'b000);
    applyStimulus("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 3'b010);
    applyStimulus("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b100);
    applyStimulus("subnormal", 32'h00000001, 32'h00000000, 1'b1, 32'h00000000, 3'b000);
    applyStimulus("inf_fin",   32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 3'b000);

    // Stream of 8 pairs with the consumer stalled for three cycles
    p0   = popped;
    cyc  = 0;
    sent = 0;
    while (sent < 8 && cyc < 100) begin
      dataa    = genOperand();
      datab    = genPartner(dataa);
      add_sub  = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      do begin
        out_ready = !(cyc >= 5 && cyc < 8);
        #1;
        acc = in_ready;
        if (cyc == 5) checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
        @(negedge clock);
        cyc++;
      end while (!acc && cyc < 100);
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("stall_delivered", 64'(popped - p0), 64'(8));

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      dataa    = genOperand();
      datab    = genPartner(dataa);
      add_sub  = 1'b1;
      in_valid = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("inflight_rst_valid", 64'(out_valid), 64'(0));
    checkOutput("inflight_rst_result", 64'(result), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    checkOutput("no_stale", 64'(stale), 64'(0));
    applyStimulus("post_reset", 32'h40400000, 32'h3F800000, 1'b1, 32'h40800000, 3'b000);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      dataa     = genOperand();
      datab     = genPartner(dataa);
      add_sub   = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("random_drained", 64'(exp_q.size()), 64'(0));

    // Double-width instance
    dataa64    = 64'h3FF0000000000000;
    datab64    = 64'h4000000000000000;
    add_sub64  = 1'b1;
    in_valid64 = 1'b1;
    @(negedge clock);
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("w64_latency", 64'(lat), 64'(4));
    checkOutput("w64_result", result64, 64'h4008000000000000);
    checkOutput("w64_flags", 64'(flags64), 64'(0));
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; W = 1+EXP_W+MAN_W (32 default; 11/52 gives binary64).
REQ-003 SHALL have port clock, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair present.
REQ-006 SHALL have port in_ready, output, 1, pipeline accepts an operand pair this cycle.
REQ-007 SHALL have port add_sub, input, 1, 1 = dataa+datab, 0 = dataa-datab.
REQ-008 SHALL have ports dataa and datab, input, W each, IEEE-754-format operands.
REQ-009 SHALL have port result, output, W, sum/difference.
REQ-010 SHALL have port flags, output, 3, {invalid, overflow, underflow} for the result.
REQ-011 SHALL have port out_valid, output, 1, result/flags valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.

Function
REQ-013 SHALL be a 4-stage pipeline: S1 unpack/classify/compare-swap; S2 align smaller significand with guard/round/sticky; S3 add or subtract, leading-zero count, normalise; S4 round, pack, flags.
REQ-014 SHALL have a latency of exactly 4 cycles from an accepted input to out_valid when no stall occurs.
REQ-015 SHALL accept a transfer when in_valid && in_ready, and SHALL complete an output transfer when out_valid && out_ready.
REQ-016 SHALL advance all stages together when advance = !out_valid || out_ready; when advance is 0, all stage registers SHALL hold.
REQ-017 SHALL drive in_ready = advance, combinationally, so throughput is 1 pair per cycle with no bubbles under continuous out_ready.
REQ-018 SHALL carry a valid bit through each stage; bubble stages SHALL advance but not assert out_valid.
REQ-019 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL flush subnormal inputs (exp=0) to signed zero before processing.
REQ-021 SHALL flush a result whose exponent underflows below 1 to signed zero and set underflow.
REQ-022 SHALL round to nearest, ties to even, using guard/round/sticky; sticky SHALL be the OR of all bits shifted out.
REQ-023 SHALL set the alignment shift to saturate at MAN_W+3, so the smaller operand then contributes only sticky.
REQ-024 SHALL, when a rounding carry-out increments the exponent, renormalise the result.
REQ-025 SHALL produce signed infinity and set overflow on exponent overflow, including after rounding.
REQ-026 SHALL return canonical quiet NaN (sign 0, exp all 1s, fraction MSB 1, rest 0) for any NaN input, and for inf-inf under the effective operation.
REQ-027 SHALL set invalid only for signalling-NaN inputs and for effective inf-inf.
REQ-028 SHALL return inf with the infinite operand's sign for inf combined with a finite operand, with no flags set.
REQ-029 SHALL make an exact-zero result of an effective subtraction +0; (-0)+(-0) SHALL give -0.
REQ-030 SHALL perform effective subtraction as sign(a) XOR sign(b) XOR !add_sub.

Reset
REQ-031 SHALL, when resetn is low, asynchronously clear all stage valid bits, out_valid=0, result=0 and flags=0.
REQ-032 SHALL discard all in-flight operations on reset, including those held by a stall.
REQ-033 SHALL accept input on the first clock edge after resetn deasserts, with in_ready=1 since out_valid=0.

Verification
REQ-034 Bench SHALL cover: add_sub=1, 3F800000+40000000 -> result 40400000, flags 000, out_valid exactly 4 cycles after acceptance.
REQ-035 Bench SHALL cover: add_sub=0, 3F800000-3F800000 -> 00000000; add_sub=1, 80000000+80000000 -> 80000000.
REQ-036 Bench SHALL cover rounding: 3F800000+33800000 -> 3F800000; 3F800001+33800000 -> 3F800002.
REQ-037 Bench SHALL cover specials: 7F7FFFFF+7F7FFFFF -> 7F800000 with overflow=1; 7F800000-7F800000 -> 7FC00000 with invalid=1; 00000001+00000000 -> 00000000.
REQ-038 Bench SHALL cover stalls: stream 8 pairs with in_valid=1 while out_ready is low for 3 cycles mid-stream -> all 8 results in order, none lost or duplicated, result stable during the stall.
REQ-039 Bench SHALL cover reset: assert resetn low with 3 operations in flight -> out_valid=0 immediately; after release, no stale results appear and a new pair returns after 4 cycles.
REQ-040 Bench SHALL cover width: instantiate EXP_W=11, MAN_W=52 and check 3FF0000000000000+4000000000000000 -> 4008000000000000.
